game_ctrl: RTL

- Game-state sequencer for the jump/obstacle VGA game.
- Sits downstream of the collision detector, the obstacle mover and vga_sync. Sits upstream of the movement controllers, the 7-segment BCD decoders and the status LED.
- Converts the raw start button, the collision level and the obstacle-wrap pulse into run/freeze control, a two-digit BCD score, a best score and a game-over blink.
- Replaces the free-running binary counter plus binary-to-BCD path.

---
 rtl/game_pkg.sv | 11 +
 rtl/bcd2_counter.sv | 28 ++
 rtl/game_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and score limits for the game sequencer.
package game_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_OVER = 2'd3
    } state_t;
    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic [7:0] SCORE_MAX = 8'h99;
endpackage

// File: rtl/bcd2_counter.sv
// bcd2_counter: two-digit BCD incrementer with clear priority, saturating at 99.
module bcd2_counter
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] uni,
    output logic [3:0] dec
);
    logic [3:0] uni_d, dec_d;
    logic       step;
    always_comb begin
        step  = inc && ({dec, uni} != SCORE_MAX);
        uni_d = clr ? 4'd0 : step ? ((uni == BCD_MAX) ? 4'd0 : uni + 4'd1) : uni;
        dec_d = clr ? 4'd0 : (step && uni == BCD_MAX) ? dec + 4'd1 : dec;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            uni <= 4'd0;
            dec <= 4'd0;
        end else begin
            uni <= uni_d;
            dec <= dec_d;
        end
    end
endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: game-state sequencer turning start/hit/pass events into run control,
// BCD score, best score and the status LED.
module game_ctrl
    import game_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int HOLD_FRAMES  = 60,
    parameter int BLINK_FRAMES = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       hit,
    input  logic       obs_pass,
    input  logic       frame_tick,
    output logic       run,
    output logic       game_over,
    output logic [1:0] state,
    output logic [3:0] score_uni,
    output logic [3:0] score_dec,
    output logic [3:0] best_uni,
    output logic [3:0] best_dec,
    output logic       led_blink
);
    localparam int HW = $clog2(HOLD_FRAMES);
    localparam int BW = $clog2(BLINK_FRAMES);
    localparam int MW = HW > BW ? HW : BW;
    localparam int CW = MW < 1 ? 1 : MW;
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_FRAMES - 1);
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_FRAMES - 1);

    state_t                 cur, nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   start_q, start_rise, obs_q, pass_rise;
    logic                   hold_done, blink_wrap, led_q, led_d, score_clr, score_inc;
    logic [CW-1:0]          cnt, cnt_d;
    logic [7:0]             score;

    assign start_rise = sync[SYNC_STAGES-1] & ~start_q;
    assign hold_done  = cur == ST_HOLD && frame_tick && cnt == HOLD_LAST;
    assign blink_wrap = cur == ST_OVER && frame_tick && cnt == BLINK_LAST;
    assign score      = {score_dec, score_uni};
    assign score_clr  = start_rise && (cur == ST_IDLE || cur == ST_OVER);
    assign score_inc  = cur == ST_RUN && !hit && pass_rise;

    bcd2_counter u_score (
        .clk (clk),
        .rst (reset),
        .clr (score_clr),
        .inc (score_inc),
        .uni (score_uni),
        .dec (score_dec)
    );

    always_ff @(posedge clk) begin
        if (reset) cur <= ST_IDLE;
        else       cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        case (cur)
            ST_IDLE, ST_OVER: nxt = start_rise ? ST_RUN : cur;
            ST_RUN:           nxt = hit ? ST_HOLD : cur;
            ST_HOLD:          nxt = hold_done ? ST_OVER : cur;
            default:          nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        run       = cur == ST_RUN;
        game_over = cur == ST_OVER;
        state     = cur;
        led_blink = led_q;
    end

    // One counter serves as the HOLD frame counter and, once in OVER, the blink divider.
    always_comb begin
        cnt_d = (cur != ST_HOLD && cur != ST_OVER) ? '0 :
                !frame_tick ? cnt :
                (hold_done || blink_wrap) ? '0 : cnt + 1'b1;
        led_d = nxt == ST_IDLE ? 1'b0 :
                (cur != ST_OVER || nxt != ST_OVER) ? 1'b1 :
                blink_wrap ? ~led_q : led_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync      <= '0;
            start_q   <= 1'b0;
            obs_q     <= 1'b0;
            pass_rise <= 1'b0;
            cnt       <= '0;
            led_q     <= 1'b0;
            best_uni  <= 4'd0;
            best_dec  <= 4'd0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], start_btn};
            start_q   <= sync[SYNC_STAGES-1];
            obs_q     <= obs_pass;
            pass_rise <= obs_pass & ~obs_q;
            cnt       <= cnt_d;
            led_q     <= led_d;
            if (hold_done && score > {best_dec, best_uni}) {best_dec, best_uni} <= score;
        end
    end
endmodule
